joypad_responder: RTL
=====================

JOYPAD_RESPONDER -- requirements
Module: joypad_responder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd50000; consecutive stable cycles required to accept a button change.
REQ-002 Parameter TURBO_DIV, default 24'd350000; clock cycles per turbo half-period.
REQ-003 clock  input  1  system clock; all state on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 btn_n  input  8  raw buttons, active-low (pulled up); bit order A,B,Select,Start,Up,Down,Left,Right = bit0..7.
REQ-006 turbo_en  input  2  bit0 enables turbo on A, bit1 on B; synchronous to clock.
REQ-007 joy_strobe  input  1  latch line from console; asynchronous to clock.
REQ-008 joy_clock  input  1  shift clock from console; asynchronous to clock.
REQ-009 joy_data  output  1  serial data to console; low = pressed; registered.
REQ-010 buttons  output  8  debounced, active-high button state (pre-turbo).
REQ-011 read_count  output  4  shifts since last load, saturating at 8.
REQ-012 frame_read  output  1  one-cycle pulse when read_count goes 7 -> 8.

Function
REQ-013 joy_strobe and joy_clock SHALL each pass through a 2-flop synchronizer before any use; a third flop SHALL provide edge detection.
REQ-014 Each btn_n bit SHALL be debounced independently: buttons[i] updates to ~btn_n[i] only after that input has differed from buttons[i] for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count from 0.
REQ-015 The turbo phase SHALL toggle every TURBO_DIV cycles from a free-running counter that wraps to 0 on reaching TURBO_DIV-1.
REQ-016 The effective value of A (B) SHALL be buttons[0] & phase when turbo_en[0] (turbo_en[1]) is set; otherwise it equals buttons[0] (buttons[1]); bits 2..7 SHALL always be buttons[7:2].
REQ-017 While synchronized strobe is high, the 8-bit shift register SHALL load the effective buttons every cycle and read_count SHALL be 0.
REQ-018 On a synchronized joy_clock rising edge with strobe low, the register SHALL shift right with 1 entering bit7, and read_count SHALL increment, saturating at 8.
REQ-019 When the synchronized strobe is high in the same cycle as a clock rising edge, load SHALL win and no shift occurs.
REQ-020 joy_data SHALL register ~shreg[0]; after 8 or more shifts, joy_data SHALL be 0, matching a stock pad with its serial input grounded.
REQ-021 Latency from a pin edge to the joy_data update SHALL be at most 4 clock cycles; console pulses narrower than 3 clock cycles are unsupported.
REQ-022 frame_read SHALL pulse exactly once per load/read sequence, and SHALL NOT pulse on further clocks once read_count is saturated.

Reset
REQ-023 On reset_n low, all of the following SHALL clear asynchronously: synchronizers, shift register, debounce counters, buttons, turbo counter and phase, read_count and frame_read.
REQ-024 joy_data SHALL reset to 1 (no buttons pressed).
REQ-025 Deassertion mid-transfer SHALL require a fresh strobe; shifts seen before that strobe output 1s shifted into a zero register.

Structure
REQ-026 A shared package joypad_pkg SHALL hold the button index constants (BTN_A..BTN_RIGHT) and the default DEBOUNCE_CYCLES and TURBO_DIV values.
REQ-027 Debounce SHALL be a sub-module btn_debounce (one bit, parameterized count width), instantiated 8 times; everything else stays in joypad_responder.

Verification
REQ-028 Hold btn_n=8'hFE stable, strobe pulse, then 8 clocks -> joy_data sequence 0,1,1,1,1,1,1,1; frame_read pulses once; read_count=8.
REQ-029 Apply 4 further clocks after REQ-028 -> joy_data=0 on each; no further frame_read pulse; read_count stays 8.
REQ-030 With DEBOUNCE_CYCLES=8, toggle btn_n[3] every 5 cycles, then hold it low -> buttons[3] stays 0 until 8 stable cycles, then becomes 1.
REQ-031 Set turbo_en=2'b01, hold A, TURBO_DIV=4 -> effective A alternates every 4 cycles; a strobe/read during phase 0 returns A released.
REQ-032 Raise strobe coincident with a clock rising edge -> load wins; joy_data reflects bit0 of the freshly loaded value.
REQ-033 Assert reset_n low after 3 of 8 shifts -> joy_data=1 within the reset; subsequent clocks without a strobe output 1 (joy_data stays 1 until the shifted-in 1s reach bit0).

Source files
------------

// File: rtl/joypad_pkg.sv
// Shared joypad constants: serial bit positions of each button and default timing values.
package joypad_pkg;
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int NUM_BTNS   = 8;

    localparam logic [15:0] DEBOUNCE_DEFAULT  = 16'd50000;
    localparam logic [23:0] TURBO_DIV_DEFAULT = 24'd350000;
endpackage

// File: rtl/btn_debounce.sv
// One-bit debouncer: output follows the inverted raw pin after LIMIT+1 consecutive differing cycles.
// Latency LIMIT+1 cycles from a stable change; no backpressure.
module btn_debounce
    import joypad_pkg::*;
#(
    parameter int               CNT_W = 16,
    parameter logic [CNT_W-1:0] LIMIT = '1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_n_i,
    output logic btn_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_q, btn_d;

    always_comb begin
        cnt_d = '0;
        btn_d = btn_q;
        // Any cycle where the pin agrees with the accepted state restarts the count.
        if ((~raw_n_i) != btn_q) begin
            if (cnt_q == LIMIT) begin
                btn_d = ~raw_n_i;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            btn_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            btn_q <= btn_d;
        end
    end

    assign btn_o = btn_q;
endmodule

// File: rtl/joypad_responder.sv
// Console-side joypad shift register with debounce and turbo on A/B.
// Pin edge to joy_data in at most 4 cycles; console drives timing, no backpressure.
module joypad_responder
    import joypad_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter logic [23:0] TURBO_DIV       = TURBO_DIV_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] btn_n,
    input  logic [1:0] turbo_en,
    input  logic       joy_strobe,
    input  logic       joy_clock,
    output logic       joy_data,
    output logic [7:0] buttons,
    output logic [3:0] read_count,
    output logic       frame_read
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 16'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DEBOUNCE_CYCLES - 16'd1);

    logic [1:0]  strb_q;
    logic [2:0]  jclk_q;
    logic [23:0] tcnt_q, tcnt_d;
    logic        phase_q, phase_d;
    logic [7:0]  sh_q, sh_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        frame_q, frame_d;
    logic        data_q;
    logic [7:0]  eff;
    logic        strb_s;
    logic        jclk_rise;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
        btn_debounce #(
            .CNT_W (DB_W),
            .LIMIT (DB_LIMIT)
        ) u_db (
            .clock   (clock),
            .reset_n (reset_n),
            .raw_n_i (btn_n[i]),
            .btn_o   (buttons[i])
        );
    end

    assign strb_s    = strb_q[1];
    assign jclk_rise = jclk_q[1] & ~jclk_q[2];

    always_comb begin
        tcnt_d  = tcnt_q + 24'd1;
        phase_d = phase_q;
        if (tcnt_q == TURBO_DIV - 24'd1) begin
            tcnt_d  = '0;
            phase_d = ~phase_q;
        end

        eff        = buttons;
        eff[BTN_A] = buttons[BTN_A] & (phase_q | ~turbo_en[0]);
        eff[BTN_B] = buttons[BTN_B] & (phase_q | ~turbo_en[1]);

        sh_d    = sh_q;
        cnt_d   = cnt_q;
        frame_d = 1'b0;
        // Strobe has priority so a clock edge coinciding with latch never shifts.
        if (strb_s) begin
            sh_d  = eff;
            cnt_d = '0;
        end else if (jclk_rise) begin
            sh_d    = {1'b1, sh_q[7:1]};
            frame_d = (cnt_q == 4'd7);
            if (cnt_q != 4'd8) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            strb_q  <= '0;
            jclk_q  <= '0;
            tcnt_q  <= '0;
            phase_q <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= '0;
            frame_q <= 1'b0;
            data_q  <= 1'b1;
        end else begin
            strb_q  <= {strb_q[0], joy_strobe};
            jclk_q  <= {jclk_q[1:0], joy_clock};
            tcnt_q  <= tcnt_d;
            phase_q <= phase_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            data_q  <= ~sh_q[0];
        end
    end

    assign joy_data   = data_q;
    assign read_count = cnt_q;
    assign frame_read = frame_q;
endmodule
